// File: rtl/btn_pkg.sv
// Shared encodings for the push-button debounce/event front end.
// No logic; consumed by btn_db_channel and btn_event_ctrl.
package btn_pkg;

   typedef enum logic [1:0] {
      ZERO  = 2'b00,
      WAIT0 = 2'b01,
      ONE   = 2'b10,
      WAIT1 = 2'b11
   } db_state_t;

   localparam int CNT_W = 4;

   localparam logic EV_PRESS   = 1'b1;
   localparam logic EV_RELEASE = 1'b0;

endpackage

// File: rtl/btn_db_channel.sv
// One switch channel: 2-flop synchronizer plus tick-gated debounce FSM.
// Latency: 2 clk sync + STABLE ticks; press/release pulses are combinational on the accepting tick.
// Backpressure: none, event pulses are single-cycle and must be captured by the parent.
module btn_db_channel
   import btn_pkg::*;
#(
   parameter int STABLE = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic sw,
   input  logic tick,
   output logic db_level,
   output logic press_tick,
   output logic release_tick
);

   localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE);

   logic             sync_q1;
   logic             s;
   db_state_t        state;
   db_state_t        state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [CNT_W-1:0] cnt_inc;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q1 <= 1'b0;
         s       <= 1'b0;
      end else begin
         sync_q1 <= sw;
         s       <= sync_q1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ZERO;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   assign cnt_inc = cnt + CNT_W'(1);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      if (tick) begin
         case (state)
            ZERO: begin
               if (s) begin
                  if (STABLE == 1) begin
                     state_nxt = ONE;
                  end else begin
                     state_nxt = WAIT1;
                     cnt_nxt   = CNT_W'(1);
                  end
               end
            end
            WAIT1: begin
               if (!s) begin
                  state_nxt = ZERO;
                  cnt_nxt   = '0;
               end else if (cnt_inc == STABLE_C) begin
                  state_nxt = ONE;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt_inc;
               end
            end
            ONE: begin
               if (!s) begin
                  if (STABLE == 1) begin
                     state_nxt = ZERO;
                  end else begin
                     state_nxt = WAIT0;
                     cnt_nxt   = CNT_W'(1);
                  end
               end
            end
            WAIT0: begin
               if (s) begin
                  state_nxt = ONE;
                  cnt_nxt   = '0;
               end else if (cnt_inc == STABLE_C) begin
                  state_nxt = ZERO;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt_inc;
               end
            end
            default: begin
               state_nxt = ZERO;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

   // A bounce back from WAITx to its origin state is not a level change, so
   // only crossings between the ZERO side and the ONE side produce events.
   always_comb begin
      db_level     = (state == ONE) || (state == WAIT0);
      press_tick   = ((state == ZERO) || (state == WAIT1)) && (state_nxt == ONE);
      release_tick = ((state == ONE) || (state == WAIT0)) && (state_nxt == ZERO);
   end

endmodule

// File: rtl/btn_event_ctrl.sv
// N-channel debounced button front end with pending flags and a round-robin event port (release events with BTN_RELEASE_EVENTS_EN).
// Latency: FSM event at t -> pend at t+1 -> ev_valid at t+2 when the output register is free.
// Backpressure: ev_valid/ev_ready; held event is stable, a second event on a pending channel is dropped and sets overrun.
module btn_event_ctrl
   import btn_pkg::*;
#(
   parameter  int N_SW    = 4,
   parameter  int PRESC_W = 16,
   parameter  int STABLE  = 3,
   localparam int ID_W    = $clog2(N_SW)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [N_SW-1:0]   sw,
   output logic [N_SW-1:0]   db_level,
   output logic              ev_valid,
   input  logic              ev_ready,
   output logic [ID_W-1:0]   ev_id,
   output logic              ev_press,
   output logic [N_SW-1:0]   pend,
   output logic              overrun,
   input  logic              ovr_clr
);

   logic [PRESC_W-1:0] presc;
   logic               tick;
   logic [N_SW-1:0]    press_tick;
   logic [N_SW-1:0]    release_tick;
   logic [N_SW-1:0]    ev_set;
   logic [N_SW-1:0]    gnt_vec;
   logic [N_SW-1:0]    drop;
   logic [ID_W-1:0]    rr;
   logic [ID_W-1:0]    winner;
   logic               any_pend;
   logic               load_en;
   logic               grant;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc <= '0;
      end else begin
         presc <= presc + PRESC_W'(1);
      end
   end

   assign tick = &presc;

   for (genvar i = 0; i < N_SW; i++) begin : g_ch
      btn_db_channel #(
         .STABLE(STABLE)
      ) u_ch (
         .clk          (clk),
         .reset        (reset),
         .sw           (sw[i]),
         .tick         (tick),
         .db_level     (db_level[i]),
         .press_tick   (press_tick[i]),
         .release_tick (release_tick[i])
      );
   end

`ifdef BTN_RELEASE_EVENTS_EN
   assign ev_set = press_tick | release_tick;
`else
   logic unused_release;
   assign ev_set         = press_tick;
   assign unused_release = ^release_tick;
`endif

   // First pending channel at or after rr, wrapping at N_SW.
   always_comb begin
      any_pend = 1'b0;
      winner   = '0;
      for (int k = 0; k < N_SW; k++) begin
         if (!any_pend && pend[(int'(rr) + k) % N_SW]) begin
            any_pend = 1'b1;
            winner   = ID_W'((int'(rr) + k) % N_SW);
         end
      end
   end

   assign load_en = !ev_valid || ev_ready;
   assign grant   = load_en && any_pend;

   always_comb begin
      gnt_vec = '0;
      if (grant) begin
         gnt_vec[winner] = 1'b1;
      end
   end

   // A flag being granted this cycle frees its slot, so a coincident new
   // event on that channel replaces it instead of counting as an overrun.
   assign drop = ev_set & pend & ~gnt_vec;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend    <= '0;
         overrun <= 1'b0;
      end else begin
         pend <= (pend & ~gnt_vec) | ev_set;
         if (|drop) begin
            overrun <= 1'b1;
         end else if (ovr_clr) begin
            overrun <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ev_valid <= 1'b0;
         ev_id    <= '0;
         rr       <= '0;
      end else if (load_en) begin
         if (any_pend) begin
            ev_valid <= 1'b1;
            ev_id    <= winner;
            rr       <= (winner == ID_W'(N_SW - 1)) ? '0 : winner + ID_W'(1);
         end else begin
            ev_valid <= 1'b0;
         end
      end
   end

`ifdef BTN_RELEASE_EVENTS_EN
   logic [N_SW-1:0] ptype;
   logic [N_SW-1:0] ptype_upd;

   assign ptype_upd = ev_set & ~drop;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptype <= '0;
      end else begin
         ptype <= (ptype & ~ptype_upd) | (press_tick & ptype_upd);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ev_press <= EV_RELEASE;
      end else if (grant) begin
         ev_press <= ptype[winner];
      end
   end
`else
   assign ev_press = EV_PRESS;
`endif

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Directed bench for btn_event_ctrl with an event scoreboard (N_SW=4, PRESC_W=2, STABLE=3).
module tb_btn_event_ctrl;

   localparam int N_SW    = 4;
   localparam int PRESC_W = 2;
   localparam int STABLE  = 3;
   localparam int ID_W    = 2;

`ifdef BTN_RELEASE_EVENTS_EN
   localparam logic RST_PRESS   = 1'b0;
   localparam logic REL_OVERRUN = 1'b1;
`else
   localparam logic RST_PRESS   = 1'b1;
   localparam logic REL_OVERRUN = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            reset;
   logic [N_SW-1:0] sw;
   logic [N_SW-1:0] db_level;
   logic            ev_valid;
   logic            ev_ready;
   logic [ID_W-1:0] ev_id;
   logic            ev_press;
   logic [N_SW-1:0] pend;
   logic            overrun;
   logic            ovr_clr;

   typedef struct {
      logic [ID_W-1:0] id;
      logic            press;
   } ev_t;

   ev_t exp_q[$];
   int  acc_cyc[$];
   int  vectors      = 0;
   int  miscompares  = 0;
   int  cycle        = 0;
   int  valid_cycles = 0;
   int  v0;
   logic            prev_hold  = 1'b0;
   logic [ID_W-1:0] prev_id    = '0;
   logic            prev_press = 1'b0;

   always #5 clk = ~clk;

   btn_event_ctrl #(
      .N_SW    (N_SW),
      .PRESC_W (PRESC_W),
      .STABLE  (STABLE)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .sw       (sw),
      .db_level (db_level),
      .ev_valid (ev_valid),
      .ev_ready (ev_ready),
      .ev_id    (ev_id),
      .ev_press (ev_press),
      .pend     (pend),
      .overrun  (overrun),
      .ovr_clr  (ovr_clr)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      sw    = '0;
      reset = 1'b1;
      step(2);
      reset = 1'b0;
      step(1);
   endtask

   task automatic push_ev(input logic [ID_W-1:0] id, input logic press);
      ev_t e;
      e.id    = id;
      e.press = press;
      exp_q.push_back(e);
   endtask

   task automatic chk_consecutive(input string tag);
      chk({tag, "_count"}, acc_cyc.size(), 2);
      if (acc_cyc.size() == 2) begin
         chk({tag, "_gap"}, acc_cyc[1] - acc_cyc[0], 1);
      end
   endtask

   // Output monitor: pops the scoreboard on every accepted event and checks hold stability.
   always @(negedge clk) begin
      if (reset !== 1'b0) begin
         prev_hold = 1'b0;
      end else begin
         cycle++;
         if (prev_hold) begin
            chk("hold_valid", ev_valid, 1);
            chk("hold_id", ev_id, prev_id);
            chk("hold_press", ev_press, prev_press);
         end
         if (ev_valid === 1'b1) valid_cycles++;
         if (ev_valid === 1'b1 && ev_ready === 1'b1) begin
            vectors++;
            assert (exp_q.size() > 0) else begin
               miscompares++;
               $error("FAIL spurious_event: observed id %0d press %0d, expected no event", ev_id, ev_press);
            end
            if (exp_q.size() > 0) begin
               ev_t e;
               e = exp_q.pop_front();
               chk("ev_id", ev_id, e.id);
               chk("ev_press", ev_press, e.press);
            end
            acc_cyc.push_back(cycle);
         end
         prev_hold  = (ev_valid === 1'b1) && (ev_ready === 1'b0);
         prev_id    = ev_id;
         prev_press = ev_press;
      end
   end

   initial begin
      reset    = 1'b1;
      sw       = '0;
      ev_ready = 1'b0;
      ovr_clr  = 1'b0;
      step(3);

      // reset state
      chk("rst_db_level", db_level, 0);
      chk("rst_ev_valid", ev_valid, 0);
      chk("rst_ev_id", ev_id, 0);
      chk("rst_ev_press", ev_press, RST_PRESS);
      chk("rst_pend", pend, 0);
      chk("rst_overrun", overrun, 0);
      reset = 1'b0;
      step(1);

      // single press on ch1, consumer always ready
      ev_ready = 1'b1;
      v0       = valid_cycles;
      push_ev(2'd1, 1'b1);
      sw[1] = 1'b1;
      step(10);
      chk("ch1_db_early", db_level, 4'b0000);
      chk("ch1_no_event_early", exp_q.size(), 1);
      step(14);
      chk("ch1_db_level", db_level, 4'b0010);
      chk("ch1_event_seen", exp_q.size(), 0);
      chk("ch1_valid_cycles", valid_cycles - v0, 1);
      chk("ch1_pend", pend, 0);

      // glitch on ch0 lasting two samples only
      v0    = valid_cycles;
      sw[0] = 1'b1;
      step(8);
      sw[0] = 1'b0;
      step(20);
      chk("glitch_db_level", db_level, 4'b0010);
      chk("glitch_pend", pend, 0);
      chk("glitch_no_valid", valid_cycles - v0, 0);

      // simultaneous presses, round-robin order
      do_reset();
      acc_cyc.delete();
      push_ev(2'd0, 1'b1);
      push_ev(2'd2, 1'b1);
      sw[0] = 1'b1;
      sw[2] = 1'b1;
      step(24);
      chk("rr02_drained", exp_q.size(), 0);
      chk_consecutive("rr02");
      chk("rr02_db_level", db_level, 4'b0101);
      acc_cyc.delete();
      push_ev(2'd3, 1'b1);
      push_ev(2'd1, 1'b1);
      sw[1] = 1'b1;
      sw[3] = 1'b1;
      step(24);
      chk("rr31_drained", exp_q.size(), 0);
      chk_consecutive("rr31");
      chk("rr31_db_level", db_level, 4'b1111);

      // overrun with a stalled consumer
      do_reset();
      ev_ready = 1'b0;
      sw[0]    = 1'b1;
      step(24);
      chk("ovr_held_valid", ev_valid, 1);
      chk("ovr_held_id", ev_id, 0);
      chk("ovr_pend0", pend, 0);
      sw[3] = 1'b1;
      step(24);
      chk("ovr_pend3", pend, 4'b1000);
      chk("ovr_none_yet", overrun, 0);
      sw[3] = 1'b0;
      step(24);
      chk("ovr_after_release", overrun, REL_OVERRUN);
      chk("ovr_pend_kept_rel", pend, 4'b1000);
      sw[3] = 1'b1;
      step(24);
      chk("ovr_set", overrun, 1);
      chk("ovr_pend_kept", pend, 4'b1000);
      ovr_clr = 1'b1;
      step(1);
      ovr_clr = 1'b0;
      chk("ovr_cleared", overrun, 0);
      push_ev(2'd0, 1'b1);
      push_ev(2'd3, 1'b1);
      ev_ready = 1'b1;
      step(4);
      chk("ovr_drained", exp_q.size(), 0);
      chk("ovr_pend_empty", pend, 0);
      chk("ovr_valid_low", ev_valid, 0);

      // reset in the middle of a debounce count
      do_reset();
      ev_ready = 1'b1;
      v0       = valid_cycles;
      sw[2]    = 1'b1;
      step(10);
      reset = 1'b1;
      step(2);
      chk("mid_rst_db_level", db_level, 0);
      chk("mid_rst_pend", pend, 0);
      chk("mid_rst_valid", ev_valid, 0);
      chk("mid_rst_no_event", valid_cycles - v0, 0);
      reset = 1'b0;
      push_ev(2'd2, 1'b1);
      step(10);
      chk("restart_db_early", db_level, 0);
      chk("restart_no_event_early", exp_q.size(), 1);
      step(14);
      chk("restart_db_level", db_level, 4'b0100);
      chk("restart_event_seen", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
